flp32_dot_seq: RTL and testbench

Dot-product sequencer that sits directly upstream of `flp32_mac_5stg`. It accepts a stream of FP32 element pairs terminated by a last flag and issues one multiply-accumulate per pair to the MAC. Running sums are held in a small bank of partial-sum slots, which hides the MAC's 5-cycle latency so a new pair can issue every cycle. At end of vector it reduces the partials through the same MAC and emits one FP32 result with its classification flags.

---
 rtl/flp32_pkg.sv | 23 ++
 rtl/flp32_dot_tagpipe.sv | 42 ++++
 rtl/flp32_dot_seq.sv | 209 ++++++++++++++++++++
 tb/tb_flp32_dot_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flp32_pkg.sv
// flp32_pkg: shared FP32 definitions for the dot-product sequencer.
// Contents: FP32 constants, the per-value classification flags struct and
// the sequencer state enum.
package flp32_pkg;

  localparam logic [31:0] FP32_ONE  = 32'h3f800000;
  localparam logic [31:0] FP32_ZERO = 32'h00000000;

  typedef struct packed {
    logic sign;
    logic zero;
    logic nan;
    logic inf;
  } flp32_flags_t;

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_DRAIN,
    ST_REDUCE,
    ST_DONE
  } dot_state_t;

endpackage

// File: rtl/flp32_dot_tagpipe.sv
// flp32_dot_tagpipe: fixed-latency {valid, tag} shift pipe that tracks which
// partial-sum slot each in-flight MAC operation belongs to.
// Ports:
//   clk, nrst      clock, asynchronous active-low reset
//   i_valid/i_tag  head entry, loaded every cycle
//   o_valid/o_tag  tail entry, DEPTH cycles after loading
//   o_busy         any entry in the pipe is valid
module flp32_dot_tagpipe #(
  parameter int DEPTH = 6,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_valid,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_busy
);

  logic [DEPTH-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [DEPTH];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_valid <= '0;
      for (int k = 0; k < DEPTH; k++) r_tag[k] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_tag[0]   <= i_tag;
      for (int k = 1; k < DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_tag[k]   <= r_tag[k-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_tag   = r_tag[DEPTH-1];
  assign o_busy  = |r_valid;

endmodule

// File: rtl/flp32_dot_seq.sv
// flp32_dot_seq: FP32 dot-product sequencer feeding a fixed-latency MAC.
// Each accepted element pair is issued as a*b+P[s] into the lowest free
// partial-sum slot, so the MAC latency is hidden behind NSLOT slots. At end
// of vector the used partials are folded into slot 0 through the MAC
// (P[j]*1.0+P[0]) and the final sum is emitted as a one-cycle pulse.
// Ports:
//   clk, nrst                  clock, asynchronous active-low reset
//   i_a/i_b/i_last/i_valid     element pair stream, o_ready handshake
//   o_mac_a/b/c, o_mac_valid   registered MAC issue (a*b+c)
//   i_mac_p, i_mac_* flags     MAC result, MAC_LAT cycles after issue
//   o_res, o_res_* flags       dot-product result, qualified by o_res_valid
module flp32_dot_seq
  import flp32_pkg::*;
#(
  parameter int NSLOT   = 8,
  parameter int MAC_LAT = 5
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_last,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [31:0] o_mac_a,
  output logic [31:0] o_mac_b,
  output logic [31:0] o_mac_c,
  output logic        o_mac_valid,
  input  logic [31:0] i_mac_p,
  input  logic        i_mac_sign,
  input  logic        i_mac_zero,
  input  logic        i_mac_nan,
  input  logic        i_mac_inf,
  input  logic        i_mac_valid,
  output logic [31:0] o_res,
  output logic        o_res_sign,
  output logic        o_res_zero,
  output logic        o_res_nan,
  output logic        o_res_inf,
  output logic        o_res_valid
);

  localparam int SW = $clog2(NSLOT);

  dot_state_t   r_state;
  logic [31:0]  r_part  [NSLOT];
  flp32_flags_t r_flags [NSLOT];
  logic [NSLOT-1:0] r_busy;
  logic [NSLOT-1:0] r_used;
  logic [31:0]  r_mac_a, r_mac_b, r_mac_c;
  logic         r_mac_valid;
  logic [31:0]  r_res;
  flp32_flags_t r_res_flags;
  logic         r_res_valid;

  logic          w_free_found, w_red_found;
  logic [SW-1:0] w_free_slot, w_red_slot;
  logic          w_accept, w_red_issue;
  logic          w_issue_v;
  logic [SW-1:0] w_issue_slot;
  logic          w_tail_v, w_pipe_busy;
  logic [SW-1:0] w_tail_slot;
  logic          w_unused_mac_valid;

  // Writeback is steered by the tag pipe alone, so results still in flight
  // across a reset are dropped; the MAC's own valid is not needed.
  assign w_unused_mac_valid = i_mac_valid;

  // Lowest free slot for accumulation, lowest used slot above 0 for reduction.
  always_comb begin
    w_free_found = 1'b0;
    w_free_slot  = '0;
    for (int s = NSLOT - 1; s >= 0; s--) begin
      if (!r_busy[s]) begin
        w_free_found = 1'b1;
        w_free_slot  = SW'(s);
      end
    end
    w_red_found = 1'b0;
    w_red_slot  = '0;
    for (int s = NSLOT - 1; s >= 1; s--) begin
      if (r_used[s]) begin
        w_red_found = 1'b1;
        w_red_slot  = SW'(s);
      end
    end
  end

  assign o_ready     = (r_state == ST_ACCUM) && w_free_found;
  assign w_accept    = i_valid && o_ready;
  assign w_red_issue = (r_state == ST_REDUCE) && !r_busy[0] && w_red_found;

  always_comb begin
    w_issue_v    = 1'b0;
    w_issue_slot = '0;
    if (w_accept) begin
      w_issue_v    = 1'b1;
      w_issue_slot = w_free_slot;
    end else if (w_red_issue) begin
      w_issue_v    = 1'b1;
    end
  end

  flp32_dot_tagpipe #(
    .DEPTH (MAC_LAT + 1),
    .TAG_W (SW)
  ) u_tagpipe (
    .clk     (clk),
    .nrst    (nrst),
    .i_valid (w_issue_v),
    .i_tag   (w_issue_slot),
    .o_valid (w_tail_v),
    .o_tag   (w_tail_slot),
    .o_busy  (w_pipe_busy)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_ACCUM;
      for (int s = 0; s < NSLOT; s++) begin
        r_part[s]  <= FP32_ZERO;
        r_flags[s] <= '0;
      end
      r_busy      <= '0;
      r_used      <= '0;
      r_mac_a     <= '0;
      r_mac_b     <= '0;
      r_mac_c     <= '0;
      r_mac_valid <= 1'b0;
      r_res       <= '0;
      r_res_flags <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_mac_valid <= 1'b0;
      r_res_valid <= 1'b0;

      // A slot stays busy until this edge, so no issue can target it now.
      if (w_tail_v) begin
        r_part[w_tail_slot]  <= i_mac_p;
        r_flags[w_tail_slot] <= '{sign: i_mac_sign, zero: i_mac_zero,
                                  nan: i_mac_nan, inf: i_mac_inf};
        r_busy[w_tail_slot]  <= 1'b0;
      end

      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            r_mac_a             <= i_a;
            r_mac_b             <= i_b;
            r_mac_c             <= r_part[w_free_slot];
            r_mac_valid         <= 1'b1;
            r_busy[w_free_slot] <= 1'b1;
            r_used[w_free_slot] <= 1'b1;
            if (i_last) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (r_busy == '0 && !w_pipe_busy) begin
            if (w_red_found) begin
              r_state <= ST_REDUCE;
            end else begin
              r_res       <= r_part[0];
              r_res_flags <= r_flags[0];
              r_res_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_REDUCE: begin
          // Fold P[j] into slot 0 as P[j]*1.0+P[0], one step per writeback.
          if (w_red_issue) begin
            r_mac_a            <= r_part[w_red_slot];
            r_mac_b            <= FP32_ONE;
            r_mac_c            <= r_part[0];
            r_mac_valid        <= 1'b1;
            r_busy[0]          <= 1'b1;
            r_used[w_red_slot] <= 1'b0;
          end else if (!r_busy[0]) begin
            r_res       <= r_part[0];
            r_res_flags <= r_flags[0];
            r_res_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          for (int s = 0; s < NSLOT; s++) begin
            r_part[s]  <= FP32_ZERO;
            r_flags[s] <= '0;
          end
          r_used  <= '0;
          r_state <= ST_ACCUM;
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  assign o_mac_a     = r_mac_a;
  assign o_mac_b     = r_mac_b;
  assign o_mac_c     = r_mac_c;
  assign o_mac_valid = r_mac_valid;
  assign o_res       = r_res;
  assign o_res_sign  = r_res_flags.sign;
  assign o_res_zero  = r_res_flags.zero;
  assign o_res_nan   = r_res_flags.nan;
  assign o_res_inf   = r_res_flags.inf;
  assign o_res_valid = r_res_valid;

endmodule

// File: tb/tb_flp32_dot_seq.sv
// tb_flp32_dot_seq: self-checking bench for flp32_dot_seq with a behavioural
// 5-cycle FP32 MAC model (double-precision arithmetic, repacked to FP32).
module tb_flp32_dot_seq;

  localparam int MAC_LAT = 5;
  localparam int NVEC    = 7;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic [31:0] i_a = '0, i_b = '0;
  logic        i_last = 1'b0, i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] o_mac_a, o_mac_b, o_mac_c;
  logic        o_mac_valid;
  logic [31:0] i_mac_p;
  logic        i_mac_sign, i_mac_zero, i_mac_nan, i_mac_inf, i_mac_valid;
  logic [31:0] o_res;
  logic        o_res_sign, o_res_zero, o_res_nan, o_res_inf, o_res_valid;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  flp32_dot_seq #(.NSLOT(8), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .nrst(nrst),
    .i_a(i_a), .i_b(i_b), .i_last(i_last), .i_valid(i_valid), .o_ready(o_ready),
    .o_mac_a(o_mac_a), .o_mac_b(o_mac_b), .o_mac_c(o_mac_c), .o_mac_valid(o_mac_valid),
    .i_mac_p(i_mac_p), .i_mac_sign(i_mac_sign), .i_mac_zero(i_mac_zero),
    .i_mac_nan(i_mac_nan), .i_mac_inf(i_mac_inf), .i_mac_valid(i_mac_valid),
    .o_res(o_res), .o_res_sign(o_res_sign), .o_res_zero(o_res_zero),
    .o_res_nan(o_res_nan), .o_res_inf(o_res_inf), .o_res_valid(o_res_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    logic [10:0] e;
    if (x[30:23] == 8'hff) e = 11'h7ff;
    else e = {3'b000, x[30:23]} + 11'd896;
    if (x[30:23] == 8'h00) d = {x[31], 63'h0};
    else d = {x[31], e, x[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int ee;
    logic [7:0] e8;
    d = $realtobits(r);
    if (d[62:52] == 11'h7ff)
      return {d[63], 8'hff, (d[51:0] != 52'h0) ? 23'h400000 : 23'h0};
    ee = int'(d[62:52]) - 896;
    if (ee >= 255) return {d[63], 8'hff, 23'h0};
    if (ee <= 0) return {d[63], 31'h0};
    e8 = ee[7:0];
    return {d[63], e8, d[51:29]};
  endfunction

  function automatic logic [31:0] macFn(input logic [31:0] a, b, c);
    return r2f(f2r(a) * f2r(b) + f2r(c));
  endfunction

  // MAC model: result of an issue seen in cycle X appears in cycle X+MAC_LAT.
  // It is not reset, so results in flight across a DUT reset still arrive.
  logic [MAC_LAT-1:0] mV = '0;
  logic [31:0]        mP [MAC_LAT];

  always @(posedge clk) begin
    mV    <= {mV[MAC_LAT-2:0], o_mac_valid};
    mP[0] <= macFn(o_mac_a, o_mac_b, o_mac_c);
    for (int k = 1; k < MAC_LAT; k++) mP[k] <= mP[k-1];
  end

  assign i_mac_p     = mP[MAC_LAT-1];
  assign i_mac_valid = mV[MAC_LAT-1];
  assign i_mac_sign  = i_mac_p[31];
  assign i_mac_zero  = (i_mac_p[30:0] == 31'h0);
  assign i_mac_nan   = (i_mac_p[30:23] == 8'hff) && (i_mac_p[22:0] != 23'h0);
  assign i_mac_inf   = (i_mac_p[30:23] == 8'hff) && (i_mac_p[22:0] == 23'h0);

  int          resCount = 0;
  int          issueCount = 0;
  int          lastResCyc = 0;
  logic [31:0] lastRes = '0;
  logic [3:0]  lastFlags = '0;

  always @(negedge clk) begin
    if (o_res_valid) begin
      resCount   <= resCount + 1;
      lastRes    <= o_res;
      lastFlags  <= {o_res_sign, o_res_zero, o_res_nan, o_res_inf};
      lastResCyc <= cyc;
    end
    if (o_mac_valid) issueCount <= issueCount + 1;
  end

  typedef struct packed {
    int               n;
    logic [9:0][31:0] a;
    logic [9:0][31:0] b;
    logic [31:0]      expRes;
    logic             checkRes;
    logic [3:0]       expFlags;
    logic [3:0]       flagMask;
    int               expLat;
  } vec_t;

  vec_t  vecs [NVEC];
  string vecName [NVEC];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one pair and hold it until accepted; returns at the negedge after
  // the accepting edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic last,
                               output int accCyc, output bit ok);
    i_a = a; i_b = b; i_last = last; i_valid = 1'b1;
    ok = 1'b0;
    accCyc = -1;
    for (int n = 0; n < 300 && !ok; n++) begin
      if (o_ready) begin
        accCyc = cyc;
        ok = 1'b1;
      end
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_last = 1'b0;
  endtask

  task automatic waitResult(output bit ok);
    int start;
    start = resCount;
    ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      #1;
      if (resCount != start) ok = 1'b1;
    end
  endtask

  task automatic setVec(input int idx, input string name, input int n, input logic [31:0] er,
                        input logic cr, input logic [3:0] ef, input logic [3:0] fm, input int lat);
    vecName[idx]       = name;
    vecs[idx].n        = n;
    vecs[idx].a        = '0;
    vecs[idx].b        = '0;
    vecs[idx].expRes   = er;
    vecs[idx].checkRes = cr;
    vecs[idx].expFlags = ef;
    vecs[idx].flagMask = fm;
    vecs[idx].expLat   = lat;
  endtask

  task automatic setPair(input int idx, input int k, input logic [31:0] a, input logic [31:0] b);
    vecs[idx].a[k] = a;
    vecs[idx].b[k] = b;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  acc, firstAcc, lastAcc, acc2, issueStart;
    bit  ok;

    // flags packed as {sign, zero, nan, inf}
    setVec(0, "single2x3", 1, 32'h40c00000, 1'b1, 4'b0000, 4'b1111, 8);
    setPair(0, 0, 32'h40000000, 32'h40400000);
    setVec(1, "three", 3, 32'h41600000, 1'b1, 4'b0000, 4'b1111, -1);
    setPair(1, 0, 32'h3f800000, 32'h3f800000);
    setPair(1, 1, 32'h40000000, 32'h40000000);
    setPair(1, 2, 32'h40400000, 32'h40400000);
    setVec(2, "tenOnes", 10, 32'h41200000, 1'b1, 4'b0000, 4'b1111, -1);
    for (int k = 0; k < 10; k++) setPair(2, k, 32'h3f800000, 32'h3f800000);
    setVec(3, "nanMid", 3, 32'h0, 1'b0, 4'b0010, 4'b0111, -1);
    setPair(3, 0, 32'h3f800000, 32'h3f800000);
    setPair(3, 1, 32'h7fc00000, 32'h3f800000);
    setPair(3, 2, 32'h40000000, 32'h40000000);
    setVec(4, "negative", 1, 32'hc0400000, 1'b1, 4'b1000, 4'b1111, 8);
    setPair(4, 0, 32'h3fc00000, 32'hc0000000);
    setVec(5, "cancel", 2, 32'h00000000, 1'b1, 4'b0100, 4'b1111, -1);
    setPair(5, 0, 32'h40000000, 32'h40000000);
    setPair(5, 1, 32'hc0000000, 32'h40000000);
    setVec(6, "infinity", 1, 32'h7f800000, 1'b1, 4'b0001, 4'b1111, 8);
    setPair(6, 0, 32'h7f800000, 32'h3f800000);

    #1 nrst = 1'b0;
    #1;
    checkOutput("resetResValid", o_res_valid, 1'b0);
    checkOutput("resetMacValid", o_mac_valid, 1'b0);
    checkOutput("resetRes", o_res, 32'h0);
    checkOutput("resetReady", o_ready, 1'b1);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      firstAcc = -1;
      lastAcc = -1;
      for (int k = 0; k < vecs[i].n; k++) begin
        applyStimulus(vecs[i].a[k], vecs[i].b[k], (k == vecs[i].n - 1), acc, ok);
        checkOutput({vecName[i], " accept"}, ok, 1'b1);
        if (k == 0) firstAcc = acc;
        lastAcc = acc;
      end
      checkOutput({vecName[i], " readyInDrain"}, o_ready, 1'b0);
      waitResult(ok);
      checkOutput({vecName[i], " resultSeen"}, ok, 1'b1);
      if (vecs[i].checkRes) checkOutput({vecName[i], " res"}, lastRes, vecs[i].expRes);
      checkOutput({vecName[i], " flags"}, lastFlags & vecs[i].flagMask,
                  vecs[i].expFlags & vecs[i].flagMask);
      if (vecs[i].expLat >= 0)
        checkOutput({vecName[i], " latency"}, lastResCyc - lastAcc, vecs[i].expLat);
      if (vecs[i].n == 10)
        checkOutput({vecName[i], " continuousAccept"}, lastAcc - firstAcc, 9);
    end

    // Pair held valid through DRAIN/REDUCE/DONE: only accepted after DONE.
    issueStart = issueCount;
    applyStimulus(32'h3f800000, 32'h3f800000, 1'b0, acc, ok);
    applyStimulus(32'h40000000, 32'h40000000, 1'b1, lastAcc, ok);
    checkOutput("heldReadyInDrain", o_ready, 1'b0);
    applyStimulus(32'h40000000, 32'h40400000, 1'b1, acc2, ok);
    #1;
    checkOutput("heldAccepted", ok, 1'b1);
    checkOutput("heldFirstRes", lastRes, 32'h40a00000);
    checkOutput("heldAcceptAfterDone", acc2, lastResCyc + 1);
    checkOutput("heldIssueCount", issueCount - issueStart, 4);
    waitResult(ok);
    checkOutput("heldSecondRes", lastRes, 32'h40c00000);
    checkOutput("heldSecondLatency", lastResCyc - acc2, 8);

    // Reset mid-vector with MAC operations in flight.
    for (int k = 0; k < 3; k++) applyStimulus(32'h3f800000, 32'h3f800000, 1'b0, acc, ok);
    #2 nrst = 1'b0;
    #1;
    checkOutput("midResetMacValid", o_mac_valid, 1'b0);
    checkOutput("midResetMacA", o_mac_a, 32'h0);
    checkOutput("midResetMacC", o_mac_c, 32'h0);
    checkOutput("midResetRes", o_res, 32'h0);
    checkOutput("midResetResValid", o_res_valid, 1'b0);
    @(negedge clk);
    nrst = 1'b1;
    applyStimulus(32'h40000000, 32'h40400000, 1'b1, lastAcc, ok);
    waitResult(ok);
    checkOutput("postResetSeen", ok, 1'b1);
    checkOutput("postResetRes", lastRes, 32'h40c00000);
    checkOutput("postResetFlags", lastFlags, 4'b0000);
    checkOutput("postResetLatency", lastResCyc - lastAcc, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
